// File: rtl/nibble_serial_compare.sv
// Serial unsigned magnitude comparator: walks the operands one 4-bit digit per
// cycle from the most significant digit down and stops at the first difference.
module nibble_serial_compare #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic                   gt,
  output logic                   eq,
  output logic                   lt
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [3:0] nib_a;
  logic [3:0] nib_b;

  assign nib_a = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b = b_q[{idx_q, 2'b00} +: 4];

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;

    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_TOP;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (nib_a != nib_b) begin
          gt_d    = (nib_a > nib_b);
          lt_d    = (nib_a < nib_b);
          state_d = S_FIN;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments; the operand registers
  // are small flops, not a memory, so they are reset along with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_FIN);
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_nibble_serial_compare.sv
// Bench for nibble_serial_compare: directed corner cases plus random operands,
// checked by a scoreboard fed from a digit-level reference model.
module tb_nibble_serial_compare;

  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [2:0] flags;  // {gt, eq, lt}
    int         acc;    // clock edge number at which start is accepted
    int         lat;    // edges from acceptance until done is captured
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy, done, gt, eq, lt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;
  logic [2:0] exp_hold = 3'b000;
  exp_t sb[$];

  nibble_serial_compare #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .eq    (eq),
    .lt    (lt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: the first differing digit from the top decides both the flags
  // and the time taken; equal operands examine every digit.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   k;
    k = N;
    for (int i = N - 1; i >= 0; i--) begin
      if (((a >> (4 * i)) & 16'hF) != ((b >> (4 * i)) & 16'hF)) begin
        k = N - i;
        break;
      end
    end
    e.flags = {a > b, a == b, a < b};
    e.lat   = k + 1;
    e.acc   = 0;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse; also watches the invariants.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      exp_hold = 3'b000;
    end else begin
      check("busy_and_done", {31'd0, busy & done}, 32'd0);
      if (busy) begin
        busy_cnt++;
        check("flags_while_busy", {29'd0, gt, eq, lt}, 32'd0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          fail("unexpected_done");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result_flags", {29'd0, gt, eq, lt}, {29'd0, e.flags});
          check("done_latency", cyc - e.acc + 1, e.lat);
          check("busy_cycles", busy_cnt, e.lat - 1);
          exp_hold = e.flags;
        end
        busy_cnt = 0;
      end else if (!busy) begin
        check("flags_hold", {29'd0, gt, eq, lt}, {29'd0, exp_hold});
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e     = model(a, b);
    e.acc = cyc + 1;
    a_i   = a;
    b_i   = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_i   = W'($urandom);
    b_i   = W'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      fail("timeout_waiting_result");
      sb.delete();
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    if (!done) fail("timeout_waiting_done");
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           j;
    rst_n = 1'b0;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    #1;
    check("reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Equal operands, accepted on the first edge after reset release.
    issue(16'h1234, 16'h1234);
    wait_idle();
    // Difference in the top digit: shortest run.
    issue(16'h5000, 16'h4FFF);
    wait_idle();
    issue(16'h12A4, 16'h12B4);
    wait_idle();
    // Start and new operands during RUN must be ignored.
    issue(16'h0001, 16'h0002);
    start = 1'b1;
    a_i   = 16'hFFFF;
    b_i   = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset in the middle of a comparison aborts it with no done pulse.
    issue(16'h1111, 16'h1111);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_abort_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h0ABC, 16'h0ABB);
    wait_idle();

    // Back-to-back: start held during the FIN cycle.
    issue(16'h8000, 16'h7000);
    wait_done();
    issue(16'h0003, 16'h0003);
    wait_idle();

    for (int it = 0; it < 40; it++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = W'($urandom);
        1:       rb = ra;
        default: begin
          rb = ra;
          j  = $urandom_range(0, N - 1);
          rb[4*j +: 4] = 4'($urandom);
        end
      endcase
      if ($urandom_range(0, 1) == 1 && sb.size() != 0) begin
        wait_done();
      end else begin
        wait_idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      issue(ra, rb);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "bench did not finish in time");
  end

endmodule
